sync_fifo: RTL and testbench

Single-clock, parameterised first-in/first-out buffer for passing data words between producer and consumer logic in the same clock domain. Holds up to 2^ADDR_WIDTH words, exposes full/empty status and a free-slot count, and returns read data one clock after a read request. The RTL module name is `sync_fifo`.

---
 rtl/sync_fifo.sv | 107 ++++++++++
 tb/tb_sync_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-in/first-out buffer holding up to 2^ADDR_WIDTH words.
// Read data is registered and appears one clock after an accepted read.
//
// Parameters:
//   DATA_WIDTH  width of each stored word
//   ADDR_WIDTH  storage address width; depth FIFO_SIZE = 2^ADDR_WIDTH
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   data_in      write data, sampled when a write is accepted
//   write_en_in  write request (ignored while full)
//   full_out     high when FIFO_SIZE words are stored
//   data_out     registered read data, holds when no read is accepted
//   read_en_in   read request (ignored while empty)
//   empty_out    high when no words are stored
//   free         number of free slots, FIFO_SIZE minus the stored count
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_en_in,
  output logic                  full_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  read_en_in,
  output logic                  empty_out,
  output logic [ADDR_WIDTH:0]   free
);

  localparam int FIFO_SIZE = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FIFO_SIZE_C = (ADDR_WIDTH + 1)'(FIFO_SIZE);
  localparam logic [ADDR_WIDTH:0]   COUNT_ZERO  = (ADDR_WIDTH + 1)'(0);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE     = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO   = DATA_WIDTH'(0);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_SIZE];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   count_next_s;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  wr_accept_s;
  logic                  rd_accept_s;

  // Status flags come straight from the count register, so no input reaches
  // an output combinationally.
  assign full_s      = (count_r == FIFO_SIZE_C);
  assign empty_s     = (count_r == COUNT_ZERO);
  assign wr_accept_s = write_en_in & ~full_s;
  assign rd_accept_s = read_en_in & ~empty_s;

  assign full_out  = full_s;
  assign empty_out = empty_s;
  assign free      = FIFO_SIZE_C - count_r;
  assign data_out  = data_out_r;

  // Next occupancy: a simultaneous accepted read and write cancel out.
  always_comb begin
    count_next_s = count_r;
    case ({wr_accept_s, rd_accept_s})
      2'b10:   count_next_s = count_r + COUNT_ONE;
      2'b01:   count_next_s = count_r - COUNT_ONE;
      2'b00:   count_next_s = count_r;
      2'b11:   count_next_s = count_r;
      default: count_next_s = count_r;
    endcase
  end

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, occupancy and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= COUNT_ZERO;
      data_out_r <= DATA_ZERO;
    end else begin
      count_r <= count_next_s;
      if (wr_accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      // When both are accepted the FIFO is neither empty nor full, so
      // rd_ptr_r != wr_ptr_r and the read sees only previously stored data.
      if (rd_accept_s) begin
        data_out_r <= mem_r[rd_ptr_r];
        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Directed self-checking bench for sync_fifo at default parameters
// (8-bit data, 16-word depth).
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       write_en_in;
  logic       full_out;
  logic [7:0] data_out;
  logic       read_en_in;
  logic       empty_out;
  logic [4:0] free;

  int total;
  int bad;

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .write_en_in(write_en_in),
    .full_out   (full_out),
    .data_out   (data_out),
    .read_en_in (read_en_in),
    .empty_out  (empty_out),
    .free       (free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests from the falling edge, leave values visible
  // 1 ns after the rising edge for checking.
  task automatic cyc(input logic we, input logic re, input logic [7:0] d);
    @(negedge clk);
    write_en_in = we;
    read_en_in  = re;
    data_in     = d;
    @(posedge clk);
    #1;
    write_en_in = 1'b0;
    read_en_in  = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    data_in     = 8'h00;
    write_en_in = 1'b0;
    read_en_in  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_empty", 32'(empty_out), 32'd1);
    chk("rst_full",  32'(full_out),  32'd0);
    chk("rst_free",  32'(free),      32'd16);
    chk("rst_dout",  32'(data_out),  32'h00);

    // Single word
    cyc(1'b1, 1'b0, 8'hAA);
    chk("one_push_empty", 32'(empty_out), 32'd0);
    chk("one_push_free",  32'(free),      32'd15);
    cyc(1'b0, 1'b1, 8'h00);
    chk("one_pop_dout",  32'(data_out),  32'hAA);
    chk("one_pop_empty", 32'(empty_out), 32'd1);
    chk("one_pop_free",  32'(free),      32'd16);

    // Fill 0..15
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      chk("fill_full", 32'(full_out), (i == 15) ? 32'd1 : 32'd0);
      chk("fill_free", 32'(free),     32'(15 - i));
    end

    // Overflow: 17th word ignored
    cyc(1'b1, 1'b0, 8'h55);
    chk("ovf_full", 32'(full_out), 32'd1);
    chk("ovf_free", 32'(free),     32'd0);

    // Drain 0..15
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("drain_dout",  32'(data_out),  32'(i));
      chk("drain_empty", 32'(empty_out), (i == 15) ? 32'd1 : 32'd0);
      chk("drain_full",  32'(full_out),  32'd0);
    end

    // Underflow: data_out holds, flags unchanged
    cyc(1'b0, 1'b1, 8'h00);
    chk("udf_dout",  32'(data_out),  32'h0F);
    chk("udf_empty", 32'(empty_out), 32'd1);
    chk("udf_full",  32'(full_out),  32'd0);
    chk("udf_free",  32'(free),      32'd16);

    // Simultaneous read/write with 3 stored, crossing pointer wrap
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h80 + i));
    end
    chk("pre_sim_free", 32'(free), 32'd13);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 8'(8'h83 + i));
      chk("sim_dout", 32'(data_out), 32'(8'h80 + i));
      chk("sim_free", 32'(free),     32'd13);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("sim_tail_dout", 32'(data_out), 32'(8'h94 + i));
    end
    chk("sim_tail_empty", 32'(empty_out), 32'd1);

    // Both requested while empty: write only
    cyc(1'b1, 1'b1, 8'h11);
    chk("both_empty_free",  32'(free),      32'd15);
    chk("both_empty_empty", 32'(empty_out), 32'd0);
    chk("both_empty_dout",  32'(data_out),  32'h96);

    // Fill to full, then both requested: read only
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h20 + i));
    end
    chk("refill_full", 32'(full_out), 32'd1);
    cyc(1'b1, 1'b1, 8'h77);
    chk("both_full_dout", 32'(data_out), 32'h11);
    chk("both_full_free", 32'(free),     32'd1);
    chk("both_full_full", 32'(full_out), 32'd0);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("both_full_drain", 32'(data_out), 32'(8'h20 + i));
    end
    chk("both_full_end_empty", 32'(empty_out), 32'd1);

    // Mid-operation asynchronous reset with 8 words stored
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h40 + i));
    end
    cyc(1'b0, 1'b1, 8'h00);
    chk("mid_pre_dout", 32'(data_out), 32'h40);
    chk("mid_pre_free", 32'(free),     32'd8);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_empty", 32'(empty_out), 32'd1);
    chk("mid_rst_full",  32'(full_out),  32'd0);
    chk("mid_rst_free",  32'(free),      32'd16);
    chk("mid_rst_dout",  32'(data_out),  32'h00);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 8'h3C);
    chk("post_rst_free", 32'(free), 32'd15);
    cyc(1'b0, 1'b1, 8'h00);
    chk("post_rst_dout",  32'(data_out),  32'h3C);
    chk("post_rst_empty", 32'(empty_out), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
